// File: rtl/bin_to_bcd_pkg.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_pkg
// Shared definitions for the binary-to-BCD display block:
//   - state_t     : conversion FSM encoding (IDLE, SHIFT, DONE)
//   - SEG_*       : 7-segment patterns, bit 6 = a ... bit 0 = g, active-high
//   - full_digits : number of BCD digits needed to hold any BIN_W-bit value
//   - seg_decode  : BCD nibble to segment pattern (10..15 map to blank)
// ---------------------------------------------------------------------------
package bin_to_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // log10(2) ~= 0.301, so this is floor(BIN_W*log10(2)) + 1 digits.
    function automatic int full_digits(input int bin_w);
        return (bin_w * 301) / 1000 + 1;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seg_scan_if.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seg_scan_if
// Bundle of all non-clock signals of bin_to_bcd_seg_scan.
//   in_valid / in_data / in_ready : request handshake from the producer
//   done                          : one-cycle completion pulse
//   bcd_out / led_out             : last result and overflow indicator
//   seg_out / dig_en              : multiplexed display pins
// master = producer/board side, slave = the converter.
// ---------------------------------------------------------------------------
interface bin_to_bcd_seg_scan_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic [BIN_W-1:0]      in_data;
    logic                  in_ready;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  led_out;
    logic [6:0]            seg_out;
    logic [DIGITS-1:0]     dig_en;

    modport master (
        output in_valid, in_data,
        input  in_ready, done, bcd_out, led_out, seg_out, dig_en
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, done, bcd_out, led_out, seg_out, dig_en
    );
endinterface

// File: rtl/bin_to_bcd_iter.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_iter
// Iterative double-dabble converter with a valid/ready request handshake.
//   clk, rst      : clock, asynchronous active-high reset
//   inValid_i     : convert inData_i (taken only while idle)
//   inData_i      : binary operand
//   inReady_o     : high while idle
//   done_o        : high for the single DONE cycle
//   capture_o     : high in the last SHIFT cycle; bcdFull_o is then the
//                   final result that becomes visible on the following edge
//   bcdFull_o     : all FULL_DIGITS BCD digits of the next shift value
// ---------------------------------------------------------------------------
module bin_to_bcd_iter
    import bin_to_bcd_pkg::*;
#(
    parameter int BIN_W       = 8,
    parameter int FULL_DIGITS = full_digits(BIN_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inValid_i,
    input  logic [BIN_W-1:0]         inData_i,
    output logic                     inReady_o,
    output logic                     done_o,
    output logic                     capture_o,
    output logic [4*FULL_DIGITS-1:0] bcdFull_o
);

    localparam int SR_W  = 4*FULL_DIGITS + BIN_W;
    localparam int CNT_W = $clog2(BIN_W);

    state_t             state_q, state_d;
    logic [SR_W-1:0]    shiftReg_q, shiftReg_d;
    logic [SR_W-1:0]    adjusted;
    logic [CNT_W-1:0]   shiftCnt_q, shiftCnt_d;

    // State, shift register and shift counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            shiftCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            shiftCnt_q <= shiftCnt_d;
        end
    end

    // Next state plus one double-dabble step: any BCD digit that would
    // reach 10 or more after doubling is pre-corrected by +3 before the
    // shift, so the carry lands in the next digit.
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        shiftCnt_d = shiftCnt_q;
        capture_o  = 1'b0;
        adjusted   = shiftReg_q;
        for (int i = 0; i < FULL_DIGITS; i++) begin
            if (adjusted[BIN_W+4*i +: 4] >= 4'd5) begin
                adjusted[BIN_W+4*i +: 4] = adjusted[BIN_W+4*i +: 4] + 4'd3;
            end
        end
        case (state_q)
            IDLE: begin
                if (inValid_i) begin
                    shiftReg_d = {{(4*FULL_DIGITS){1'b0}}, inData_i};
                    shiftCnt_d = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                shiftReg_d = {adjusted[SR_W-2:0], 1'b0};
                shiftCnt_d = shiftCnt_q + CNT_W'(1);
                if (shiftCnt_q == CNT_W'(BIN_W-1)) begin
                    state_d   = DONE;
                    capture_o = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign inReady_o = (state_q == IDLE);
    assign done_o    = (state_q == DONE);
    assign bcdFull_o = shiftReg_d[SR_W-1 -: 4*FULL_DIGITS];

endmodule

// File: rtl/bin_to_bcd_seg_scan.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seg_scan
// Binary to DIGITS-digit decimal converter driving a time-multiplexed
// common-segment 7-segment display, with overflow LED and optional
// leading-zero blanking.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of bin_to_bcd_seg_scan_if
//              (in_valid/in_data/in_ready handshake, done pulse,
//               bcd_out, led_out, seg_out, dig_en)
// ---------------------------------------------------------------------------
module bin_to_bcd_seg_scan
    import bin_to_bcd_pkg::*;
#(
    parameter int BIN_W    = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 4,
    parameter int LZ_BLANK = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    bin_to_bcd_seg_scan_if.slave  bus
);

    localparam int FULL_DIGITS = full_digits(BIN_W);
    localparam int WIDE_DIGITS = (DIGITS > FULL_DIGITS) ? DIGITS : FULL_DIGITS;
    localparam int CNT_W       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                     capture;
    logic [4*FULL_DIGITS-1:0] bcdFull;
    logic [4*WIDE_DIGITS-1:0] bcdWide;
    logic [DIGITS-1:0]        upperZero;
    logic                     zeroAcc;
    logic [3:0]               shownNib;

    logic [4*DIGITS-1:0] bcdOut_q, bcdOut_d;
    logic                led_q, led_d;
    logic                shown_q, shown_d;
    logic [CNT_W-1:0]    scanCnt_q, scanCnt_d;
    logic [IDX_W-1:0]    digIdx_q, digIdx_d;
    logic [DIGITS-1:0]   digEn_q, digEn_d;
    logic [6:0]          seg_q, seg_d;

    bin_to_bcd_iter #(
        .BIN_W       (BIN_W),
        .FULL_DIGITS (FULL_DIGITS)
    ) u_iter (
        .clk       (clk),
        .rst       (rst),
        .inValid_i (bus.in_valid),
        .inData_i  (bus.in_data),
        .inReady_o (bus.in_ready),
        .done_o    (bus.done),
        .capture_o (capture),
        .bcdFull_o (bcdFull)
    );

    // Result, overflow and scanner registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcdOut_q  <= '0;
            led_q     <= 1'b0;
            shown_q   <= 1'b0;
            scanCnt_q <= '0;
            digIdx_q  <= '0;
            digEn_q   <= DIGITS'(1);
            seg_q     <= SEG_BLANK;
        end else begin
            bcdOut_q  <= bcdOut_d;
            led_q     <= led_d;
            shown_q   <= shown_d;
            scanCnt_q <= scanCnt_d;
            digIdx_q  <= digIdx_d;
            digEn_q   <= digEn_d;
            seg_q     <= seg_d;
        end
    end

    // The full result is widened so that DIGITS larger than needed simply
    // reads zeros, and anything above the displayed digits is overflow.
    always_comb begin
        bcdWide                    = '0;
        bcdWide[4*FULL_DIGITS-1:0] = bcdFull;
        bcdOut_d = bcdOut_q;
        led_d    = led_q;
        shown_d  = shown_q;
        if (capture) begin
            bcdOut_d = bcdWide[4*DIGITS-1:0];
            led_d    = |(bcdWide >> (4*DIGITS));
            shown_d  = 1'b1;
        end
    end

    // Free-running digit scanner. Segments are decoded from the next-state
    // result and digit index so seg_out and dig_en always agree, including
    // on the edge that loads a new result.
    always_comb begin
        scanCnt_d = scanCnt_q + CNT_W'(1);
        digIdx_d  = digIdx_q;
        if (scanCnt_q == CNT_W'(SCAN_DIV-1)) begin
            scanCnt_d = '0;
            if (digIdx_q == IDX_W'(DIGITS-1)) begin
                digIdx_d = '0;
            end else begin
                digIdx_d = digIdx_q + IDX_W'(1);
            end
        end
        digEn_d = DIGITS'(1) << digIdx_d;

        // upperZero[i]: digit i and every more significant digit are zero.
        zeroAcc   = 1'b1;
        upperZero = '0;
        for (int i = DIGITS-1; i >= 0; i--) begin
            zeroAcc      = zeroAcc && (bcdOut_d[4*i +: 4] == 4'd0);
            upperZero[i] = zeroAcc;
        end

        shownNib = bcdOut_d[4*int'(digIdx_d) +: 4];
        seg_d    = seg_decode(shownNib);
        if (!shown_d) begin
            seg_d = SEG_BLANK;
        end else if ((LZ_BLANK != 0) && (digIdx_d != '0) && upperZero[digIdx_d]) begin
            seg_d = SEG_BLANK;
        end
    end

    assign bus.bcd_out = bcdOut_q;
    assign bus.led_out = led_q;
    assign bus.seg_out = seg_q;
    assign bus.dig_en  = digEn_q;

endmodule

// File: tb/tb_bin_to_bcd_seg_scan.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_seg_scan
// Drives three instances: A (defaults), B (DIGITS=2), C (LZ_BLANK=0) and
// compares against a decimal-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_seg_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seg_scan_if #(.BIN_W(8), .DIGITS(3)) ifA ();
    bin_to_bcd_seg_scan_if #(.BIN_W(8), .DIGITS(2)) ifB ();
    bin_to_bcd_seg_scan_if #(.BIN_W(8), .DIGITS(3)) ifC ();

    bin_to_bcd_seg_scan #(.BIN_W(8), .DIGITS(3), .SCAN_DIV(4), .LZ_BLANK(1))
        dutA (.clk(clk), .rst(rst), .bus(ifA));
    bin_to_bcd_seg_scan #(.BIN_W(8), .DIGITS(2), .SCAN_DIV(4), .LZ_BLANK(1))
        dutB (.clk(clk), .rst(rst), .bus(ifB));
    bin_to_bcd_seg_scan #(.BIN_W(8), .DIGITS(3), .SCAN_DIV(4), .LZ_BLANK(0))
        dutC (.clk(clk), .rst(rst), .bus(ifC));

    // Latest segment pattern seen per digit, and done pulse counts.
    logic [6:0] segA [3];
    logic [6:0] segB [2];
    logic [6:0] segC [3];
    int doneA = 0;
    int doneB = 0;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) if (ifA.dig_en[i]) segA[i] = ifA.seg_out;
        for (int i = 0; i < 2; i++) if (ifB.dig_en[i]) segB[i] = ifB.seg_out;
        for (int i = 0; i < 3; i++) if (ifC.dig_en[i]) segC[i] = ifC.seg_out;
        if (ifA.done) doneA++;
        if (ifB.done) doneB++;
    end

    // ---------------- reference model ----------------
    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [15:0] refBcd(input int v, input int nd);
        logic [15:0] r = '0;
        for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [6:0] refSeg(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    // Pattern of digit i when value v is shown on nd digits.
    function automatic logic [6:0] refDisp(input int v, input int nd, input int i, input bit lz);
        int shown = v % pow10(nd);
        if (lz && i > 0 && shown < pow10(i)) return 7'b0000000;
        return refSeg((shown / pow10(i)) % 10);
    endfunction

    // ---------------- drivers ----------------
    task automatic waitCycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic convA(input int v, output int lat);
        lat = -1;
        for (int w = 0; w < 40 && !ifA.in_ready; w++) begin @(posedge clk); #1; end
        ifA.in_valid = 1'b1;
        ifA.in_data  = 8'(v);
        @(posedge clk); #1;
        ifA.in_valid = 1'b0;
        ifA.in_data  = 8'($urandom);
        for (int c = 1; c <= 40; c++) begin
            if (ifA.done) begin lat = c; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic convB(input int v, output int lat);
        lat = -1;
        for (int w = 0; w < 40 && !ifB.in_ready; w++) begin @(posedge clk); #1; end
        ifB.in_valid = 1'b1;
        ifB.in_data  = 8'(v);
        @(posedge clk); #1;
        ifB.in_valid = 1'b0;
        ifB.in_data  = 8'($urandom);
        for (int c = 1; c <= 40; c++) begin
            if (ifB.done) begin lat = c; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic convC(input int v, output int lat);
        lat = -1;
        for (int w = 0; w < 40 && !ifC.in_ready; w++) begin @(posedge clk); #1; end
        ifC.in_valid = 1'b1;
        ifC.in_data  = 8'(v);
        @(posedge clk); #1;
        ifC.in_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (ifC.done) begin lat = c; break; end
            @(posedge clk); #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [2:0] expEnA;
        logic [1:0] expEnB;
        rst = 1'b1;
        waitCycles(3);
        rst = 1'b0;
        for (int k = 0; k < 13; k++) begin
            expEnA = 3'b001 << ((k / 4) % 3);
            expEnB = 2'b01 << ((k / 4) % 2);
            checks++;
            if (ifA.dig_en !== expEnA) begin
                failures++;
                $display("[TB] FAIL reset_dig_en_A k=%0d got %b want %b", k, ifA.dig_en, expEnA);
            end
            checks++;
            if (ifB.dig_en !== expEnB) begin
                failures++;
                $display("[TB] FAIL reset_dig_en_B k=%0d got %b want %b", k, ifB.dig_en, expEnB);
            end
            checks++;
            if ({ifA.in_ready, ifA.done, ifA.bcd_out, ifA.led_out, ifA.seg_out} !== {1'b1, 1'b0, 12'h000, 1'b0, 7'b0}) begin
                failures++;
                $display("[TB] FAIL reset_idle_A k=%0d got rdy=%b done=%b bcd=%h led=%b seg=%b want 1 0 000 0 0000000",
                         k, ifA.in_ready, ifA.done, ifA.bcd_out, ifA.led_out, ifA.seg_out);
            end
            waitCycles(1);
        end
    endtask

    task automatic test_latency();
        ifA.in_valid = 1'b1;
        ifA.in_data  = 8'd255;
        @(posedge clk); #1;
        ifA.in_valid = 1'b0;
        ifA.in_data  = 8'd3;
        for (int c = 1; c <= 12; c++) begin
            checks++;
            if (ifA.in_ready !== (c > 9) || ifA.done !== (c == 9)) begin
                failures++;
                $display("[TB] FAIL latency_hs c=%0d got rdy=%b done=%b want rdy=%b done=%b",
                         c, ifA.in_ready, ifA.done, c > 9, c == 9);
            end
            if (c == 8) begin
                checks++;
                if (ifA.bcd_out !== 12'h000) begin
                    failures++;
                    $display("[TB] FAIL latency_hold got %h want 000", ifA.bcd_out);
                end
            end
            if (c == 9) begin
                checks++;
                if (ifA.bcd_out !== 12'h255 || ifA.led_out !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL latency_result got %h led=%b want 255 led=0", ifA.bcd_out, ifA.led_out);
                end
            end
            waitCycles(1);
        end
        waitCycles(13);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (segA[i] !== refDisp(255, 3, i, 1'b1)) begin
                failures++;
                $display("[TB] FAIL latency_seg digit=%0d got %b want %b", i, segA[i], refDisp(255, 3, i, 1'b1));
            end
        end
    endtask

    task automatic test_digits2();
        int lat;
        int vals [2] = '{137, 99};
        for (int n = 0; n < 2; n++) begin
            convB(vals[n], lat);
            checks++;
            if (lat !== 9 || ifB.bcd_out !== refBcd(vals[n], 2)[7:0] || ifB.led_out !== (vals[n] >= 100)) begin
                failures++;
                $display("[TB] FAIL digits2 v=%0d got lat=%0d bcd=%h led=%b want lat=9 bcd=%h led=%b",
                         vals[n], lat, ifB.bcd_out, ifB.led_out, refBcd(vals[n], 2)[7:0], vals[n] >= 100);
            end
            waitCycles(10);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (segB[i] !== refDisp(vals[n], 2, i, 1'b1)) begin
                    failures++;
                    $display("[TB] FAIL digits2_seg v=%0d digit=%0d got %b want %b",
                             vals[n], i, segB[i], refDisp(vals[n], 2, i, 1'b1));
                end
            end
        end
    endtask

    task automatic test_blanking();
        int lat;
        int vals [2] = '{7, 0};
        for (int n = 0; n < 2; n++) begin
            convA(vals[n], lat);
            waitCycles(14);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (segA[i] !== refDisp(vals[n], 3, i, 1'b1)) begin
                    failures++;
                    $display("[TB] FAIL blank_lz v=%0d digit=%0d got %b want %b",
                             vals[n], i, segA[i], refDisp(vals[n], 3, i, 1'b1));
                end
            end
        end
        convC(7, lat);
        waitCycles(14);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (segC[i] !== refDisp(7, 3, i, 1'b0)) begin
                failures++;
                $display("[TB] FAIL blank_nolz digit=%0d got %b want %b", i, segC[i], refDisp(7, 3, i, 1'b0));
            end
        end
    endtask

    task automatic test_back_to_back();
        int startDone;
        int seen = 0;
        waitCycles(2);
        startDone = doneA;
        ifA.in_valid = 1'b1;
        ifA.in_data  = 8'd200;
        for (int c = 0; c <= 26; c++) begin
            if (c == 1) ifA.in_data = 8'd50;
            if (ifA.done) begin
                seen++;
                checks++;
                if ((seen == 1 && (c !== 9 || ifA.bcd_out !== 12'h200)) ||
                    (seen == 2 && (c !== 19 || ifA.bcd_out !== 12'h050)) || seen > 2) begin
                    failures++;
                    $display("[TB] FAIL b2b_done n=%0d got c=%0d bcd=%h want c=%0d bcd=%s",
                             seen, c, ifA.bcd_out, (seen == 1) ? 9 : 19, (seen == 1) ? "200" : "050");
                end
                if (seen == 2) ifA.in_valid = 1'b0;
            end
            waitCycles(1);
        end
        ifA.in_valid = 1'b0;
        checks++;
        if (doneA - startDone !== 2) begin
            failures++;
            $display("[TB] FAIL b2b_pulses got %0d want 2", doneA - startDone);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int snap;
        convA(12, lat);
        checks++;
        if (ifA.bcd_out !== 12'h012) begin
            failures++;
            $display("[TB] FAIL abort_pre got %h want 012", ifA.bcd_out);
        end
        waitCycles(1);
        ifA.in_valid = 1'b1;
        ifA.in_data  = 8'd255;
        waitCycles(1);
        ifA.in_valid = 1'b0;
        waitCycles(3);
        snap = doneA;
        rst  = 1'b1;
        #1;
        checks++;
        if ({ifA.in_ready, ifA.done, ifA.bcd_out, ifA.led_out, ifA.seg_out, ifA.dig_en} !==
            {1'b1, 1'b0, 12'h000, 1'b0, 7'b0, 3'b001}) begin
            failures++;
            $display("[TB] FAIL abort_reset got rdy=%b done=%b bcd=%h led=%b seg=%b en=%b want 1 0 000 0 0000000 001",
                     ifA.in_ready, ifA.done, ifA.bcd_out, ifA.led_out, ifA.seg_out, ifA.dig_en);
        end
        waitCycles(2);
        rst = 1'b0;
        waitCycles(12);
        checks++;
        if (doneA !== snap) begin
            failures++;
            $display("[TB] FAIL abort_no_done got %0d pulses want 0", doneA - snap);
        end
        convA(9, lat);
        checks++;
        if (lat !== 9 || ifA.bcd_out !== 12'h009) begin
            failures++;
            $display("[TB] FAIL abort_after got lat=%0d bcd=%h want lat=9 bcd=009", lat, ifA.bcd_out);
        end
    endtask

    task automatic test_random();
        int v;
        int lat;
        for (int n = 0; n < 20; n++) begin
            v = $urandom_range(0, 255);
            convA(v, lat);
            checks++;
            if (lat !== 9 || ifA.bcd_out !== refBcd(v, 3)[11:0] || ifA.led_out !== (v >= 1000)) begin
                failures++;
                $display("[TB] FAIL rand_A v=%0d got lat=%0d bcd=%h led=%b want lat=9 bcd=%h led=0",
                         v, lat, ifA.bcd_out, ifA.led_out, refBcd(v, 3)[11:0]);
            end
            waitCycles(14);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (segA[i] !== refDisp(v, 3, i, 1'b1)) begin
                    failures++;
                    $display("[TB] FAIL rand_A_seg v=%0d digit=%0d got %b want %b", v, i, segA[i], refDisp(v, 3, i, 1'b1));
                end
            end
            v = $urandom_range(0, 255);
            convB(v, lat);
            checks++;
            if (lat !== 9 || ifB.bcd_out !== refBcd(v, 2)[7:0] || ifB.led_out !== (v >= 100)) begin
                failures++;
                $display("[TB] FAIL rand_B v=%0d got lat=%0d bcd=%h led=%b want lat=9 bcd=%h led=%b",
                         v, lat, ifB.bcd_out, ifB.led_out, refBcd(v, 2)[7:0], v >= 100);
            end
            waitCycles(10);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (segB[i] !== refDisp(v, 2, i, 1'b1)) begin
                    failures++;
                    $display("[TB] FAIL rand_B_seg v=%0d digit=%0d got %b want %b", v, i, segB[i], refDisp(v, 2, i, 1'b1));
                end
            end
        end
    endtask

    initial begin
        ifA.in_valid = 1'b0; ifA.in_data = '0;
        ifB.in_valid = 1'b0; ifB.in_data = '0;
        ifC.in_valid = 1'b0; ifC.in_data = '0;
        #1;
        test_reset();
        test_latency();
        test_digits2();
        test_blanking();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seg_scan.md
Name: bin_to_bcd_seg_scan

Overview:
Parametrised successor to the single-digit binary-to-decimal decoder. It accepts a BIN_W-bit binary word through a valid/ready handshake and converts it to DIGITS BCD digits with an iterative shift-add-3 (double-dabble) engine. It drives a time-multiplexed common-segment 7-segment display with optional leading-zero blanking. An overflow LED lights when the value exceeds 10^DIGITS-1. It sits between the switch/counter logic and the board display pins.

Parameters:
BIN_W, 8, binary input width (>=4).
DIGITS, 3, displayed decimal digits (>=1).
SCAN_DIV, 4, clock cycles each digit stays enabled (>=1).
LZ_BLANK, 1, 1 = blank leading zero digits; digit 0 is never blanked.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  asynchronous active-high reset.
in_valid  in  1  request to convert in_data.
in_data  in  BIN_W  binary value, sampled only on the accept edge.
in_ready  out  1  high when idle, i.e. ready to accept.
done  out  1  one-cycle pulse when a conversion completes.
bcd_out  out  4*DIGITS  last result; digit i in bits [4i+3:4i], digit 0 is least significant.
led_out  out  1  overflow: the value did not fit in DIGITS digits.
seg_out  out  7  segments, seg_out[6]=a … seg_out[0]=g, active-high.
dig_en  out  DIGITS  one-hot digit enable, active-high; bit i selects digit i.

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- Reset values: state IDLE, in_ready=1, done=0, bcd_out=0, led_out=0, seg_out=7'b0000000, dig_en=1 (digit 0), scan counters 0, shown_valid=0.
- Internal width: FULL_DIGITS = (BIN_W*301)/1000 + 1.
  - The shift register is 4*FULL_DIGITS BCD bits plus BIN_W binary bits.
- FSM states:
  - IDLE: in_ready=1. If in_valid is high at an edge, load in_data, clear the BCD field, clear the counter, go to SHIFT.
  - SHIFT: runs exactly BIN_W cycles. Each cycle, every BCD nibble >=5 gets +3, then the whole register shifts left by 1. After the BIN_W-th shift, go to DONE.
  - DONE: done=1 for this single cycle, then return to IDLE.
  - On the edge entering DONE: bcd_out takes the low DIGITS nibbles, led_out = OR of the nibbles above DIGITS-1, shown_valid=1. When DIGITS >= FULL_DIGITS, the upper nibbles are zero-filled and led_out=0.
- Latency and throughput:
  - Accept edge = cycle 0; done is high in cycle BIN_W+1; in_ready is high again in cycle BIN_W+2.
  - Throughput is one conversion per BIN_W+2 cycles.
- in_valid while not IDLE is ignored (no queueing). in_data may change freely outside the accept edge.
- bcd_out, led_out and the display hold the previous result during a conversion and change only on the DONE edge.
- Scanner (runs continuously, independent of the FSM):
  - scan_cnt counts 0..SCAN_DIV-1. At wrap, the digit index advances 0→1→…→DIGITS-1→0, and dig_en rotates to match.
  - seg_out and dig_en are registered and change on the same edge.
  - With DIGITS=1, dig_en stays 1.
- Segment codes: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Nibble values 10–15 cannot occur; the decoder maps them to blank.
- Blanking: seg_out=0000000 when shown_valid=0.
  - Also blank when LZ_BLANK=1, the digit index is >0, and that digit and all more significant digits are zero.
- rst mid-conversion: aborts immediately, no done pulse, all outputs return to reset values.

Decomposition:
- Package bin_to_bcd_pkg holds:
  - the state encoding (IDLE, SHIFT, DONE);
  - segment constants SEG_0..SEG_9 and SEG_BLANK;
  - the FULL_DIGITS formula as a function.
- Sub-module bin_to_bcd_iter is the FSM plus double-dabble datapath with the handshake (in_*, done, bcd_full).
- The top adds overflow extraction, the result registers, the scanner and the segment decode.

Test Plan:
1. Reset, hold rst 3 cycles, release; no input → in_ready=1, done=0, bcd_out=0, led_out=0, seg_out=0000000 on every digit, dig_en cycles 001→010→100 every 4 cycles.
2. Defaults; in_data=255 with one-cycle in_valid → done high exactly in cycle 9, in_ready low cycles 1–9, bcd_out=12'h255, led_out=0; scan shows 1011011 (5), 1011011 (5), 1101101 (2) on dig_en 001/010/100.
3. DIGITS=2; in_data=137 → bcd_out=8'h37, led_out=1, digits show 1110000 (7) and 1111001 (3); then in_data=99 → led_out=0, bcd_out=8'h99.
4. LZ_BLANK=1; in_data=7 → digit0=1110000, digits 1–2=0000000; then in_data=0 → digit0=1111110, others blank. With LZ_BLANK=0, in_data=7 → digits 1–2=1111110.
5. in_valid held high with in_data changing 200→50 during conversion → first result 12'h200. Second accept occurs in cycle 10 and yields 12'h050; no extra done pulses.
6. Assert rst in cycle 4 of converting 255 after a previous result of 12'h012 → outputs immediately return to reset values, no done; a new request for 9 after release gives bcd_out=12'h009 in the normal latency.
